// File: rtl/mdu_iterative_if.sv
// Handshake and operand bundle between the control/regfile side and the iterative MDU.
interface mdu_iterative_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
);
    logic                     start;
    logic [2:0]               funct3;
    logic [DATA_WIDTH-1:0]    op1;
    logic [DATA_WIDTH-1:0]    op2;
    logic [ADDRESS_WIDTH-1:0] rd_in;
    logic                     busy;
    logic                     done;
    logic [DATA_WIDTH-1:0]    result;
    logic [ADDRESS_WIDTH-1:0] rd_out;
    logic                     we;

    modport master (
        output start, funct3, op1, op2, rd_in,
        input  busy, done, result, rd_out, we
    );

    modport slave (
        input  start, funct3, op1, op2, rd_in,
        output busy, done, result, rd_out, we
    );
endinterface

// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Define MDU_EARLY_OUT_EN to let divide-by-zero, signed overflow and multiply-by-zero skip CALC.
module mdu_iterative #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic           clk,
    input  logic           rst,
    mdu_iterative_if.slave bus
);
    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, next_state;

    logic [2:0]               f3;
    logic [W-1:0]             hi, lo, opb;
    logic                     neg_res, neg_rem, div_zero;
    logic [CNT_W-1:0]         count;
    logic [W-1:0]             result;
    logic [ADDRESS_WIDTH-1:0] rd_out;

    logic         in_div, a_signed, b_signed, a_neg, b_neg;
    logic [W-1:0] a_mag, b_mag;
    logic         accept, last;

    // Signedness is decided at accept time so only magnitudes and sign flags are stored.
    always_comb begin
        in_div   = bus.funct3[2];
        a_signed = in_div ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
        b_signed = in_div ? ~bus.funct3[0] : ~bus.funct3[1];
        a_neg    = a_signed & bus.op1[W-1];
        b_neg    = b_signed & bus.op2[W-1];
        a_mag    = a_neg ? -bus.op1 : bus.op1;
        b_mag    = b_neg ? -bus.op2 : bus.op2;
        accept   = (state == IDLE) && bus.start;
        last     = (state == CALC) && (count == CNT_W'(W - 1));
    end

`ifdef MDU_EARLY_OUT_EN
    logic         special;
    logic [W-1:0] special_value;

    always_comb begin
        special       = 1'b0;
        special_value = '0;
        if (in_div) begin
            if (bus.op2 == '0) begin
                special       = 1'b1;
                special_value = bus.funct3[1] ? bus.op1 : '1;
            end else if (!bus.funct3[0] && bus.op1 == {1'b1, {(W-1){1'b0}}} && bus.op2 == '1) begin
                special       = 1'b1;
                special_value = bus.funct3[1] ? '0 : bus.op1;
            end
        end else if (bus.op1 == '0 || bus.op2 == '0) begin
            special = 1'b1;
        end
    end
`endif

    // hi/lo hold {accumulator, multiplier} for multiply and {remainder, quotient} for divide.
    logic [W:0]   mul_sum, div_shift;
    logic [W-1:0] div_diff, step_hi, step_lo;
    logic         div_ge;

    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opb} : '0);
        div_shift = {hi, lo[W-1]};
        div_ge    = div_shift >= {1'b0, opb};
        div_diff  = div_shift[W-1:0] - opb;
        if (f3[2]) begin
            step_hi = div_ge ? div_diff : div_shift[W-1:0];
            step_lo = {lo[W-2:0], div_ge};
        end else begin
            step_hi = mul_sum[W:1];
            step_lo = {mul_sum[0], lo[W-1:1]};
        end
    end

    logic [2*W-1:0] prod;
    logic [W-1:0]   quo, rem, final_value;

    always_comb begin
        prod = {step_hi, step_lo};
        if (neg_res) prod = -prod;
        quo = neg_res ? -step_lo : step_lo;
        rem = neg_rem ? -step_hi : step_hi;
        if (div_zero) quo = '1;
        if (!f3[2]) final_value = (f3[1:0] == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];
        else        final_value = f3[1] ? rem : quo;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
`ifdef MDU_EARLY_OUT_EN
                    next_state = special ? DONE : CALC;
`else
                    next_state = CALC;
`endif
                end
            end
            CALC:    if (last) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            f3       <= '0;
            hi       <= '0;
            lo       <= '0;
            opb      <= '0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            count    <= '0;
            result   <= '0;
            rd_out   <= '0;
        end else if (accept) begin
            f3       <= bus.funct3;
            rd_out   <= bus.rd_in;
            count    <= '0;
            hi       <= '0;
            lo       <= in_div ? a_mag : b_mag;
            opb      <= in_div ? b_mag : a_mag;
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            div_zero <= in_div && (bus.op2 == '0);
`ifdef MDU_EARLY_OUT_EN
            if (special) result <= special_value;
`endif
        end else if (state == CALC) begin
            hi    <= step_hi;
            lo    <= step_lo;
            count <= count + CNT_W'(1);
            if (last) result <= final_value;
        end
    end

    assign bus.busy   = (state != IDLE);
    assign bus.done   = (state == DONE);
    assign bus.we     = (state == DONE) && (rd_out != '0);
    assign bus.result = result;
    assign bus.rd_out = rd_out;
endmodule

// File: tb/tb_mdu_iterative.sv
// Directed-vector bench for mdu_iterative; expected results and latencies are hand-computed.
module tb_mdu_iterative;
    localparam int DW       = 32;
    localparam int AW       = 5;
    localparam int FULL_LAT = 33;
`ifdef MDU_EARLY_OUT_EN
    localparam int SPECIAL_LAT = 1;
`else
    localparam int SPECIAL_LAT = 33;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    mdu_iterative_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

    mdu_iterative #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Issue one operation and follow it to its done pulse; with hold set, start stays high
    // and the operand/rd inputs are scrambled every cycle after acceptance.
    task automatic apply_stimulus(input string tag, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] b, input logic [4:0] rd,
                                  input logic [31:0] expected, input int lat, input bit hold);
        int   cycles;
        logic seen;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = f3;
        bus.op1    = a;
        bus.op2    = b;
        bus.rd_in  = rd;
        cycles     = 0;
        seen       = 1'b0;
        while (!seen && cycles < 3 * FULL_LAT) begin
            @(posedge clk);
            #1;
            cycles++;
            if (hold) begin
                bus.op1   = ~bus.op1;
                bus.op2   = bus.op2 + 32'd3;
                bus.rd_in = bus.rd_in + 5'd1;
            end else begin
                bus.start = 1'b0;
            end
            seen = bus.done;
        end
        check_output({tag, " done"}, 32'(seen), 32'd1);
        check_output({tag, " latency"}, 32'(cycles), 32'(lat));
        check_output({tag, " result"}, bus.result, expected);
        check_output({tag, " rd_out"}, 32'(bus.rd_out), 32'(rd));
        check_output({tag, " we"}, 32'(bus.we), 32'(rd != 5'd0));
        @(posedge clk);
        #1;
        check_output({tag, " done drop"}, 32'(bus.done), 32'd0);
        check_output({tag, " idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        logic activity;

        // Reset with start asserted at the same time: reset must win.
        rst        = 1'b1;
        bus.start  = 1'b1;
        bus.funct3 = 3'b000;
        bus.op1    = 32'd9;
        bus.op2    = 32'd9;
        bus.rd_in  = 5'd3;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset busy", 32'(bus.busy), 32'd0);
        check_output("reset done", 32'(bus.done), 32'd0);
        check_output("reset we", 32'(bus.we), 32'd0);
        check_output("reset result", bus.result, 32'd0);
        check_output("reset rd_out", 32'(bus.rd_out), 32'd0);
        rst       = 1'b0;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check_output("start lost", 32'(bus.busy), 32'd0);

        // Multiply variants
        apply_stimulus("MUL 7x-3", 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, FULL_LAT, 1'b0);
        apply_stimulus("MULH min*min", 3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000, FULL_LAT, 1'b0);
        apply_stimulus("MULHU max*max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFE, FULL_LAT, 1'b0);
        apply_stimulus("MULHSU -1x2", 3'b010, 32'hFFFF_FFFF, 32'd2, 5'd8, 32'hFFFF_FFFF, FULL_LAT, 1'b0);
        apply_stimulus("MULHU 2^16*2^16", 3'b011, 32'h0001_0000, 32'h0001_0000, 5'd9, 32'h0000_0001, FULL_LAT, 1'b0);
        apply_stimulus("MUL 0x5", 3'b000, 32'd0, 32'd5, 5'd10, 32'd0, SPECIAL_LAT, 1'b0);

        // Divide variants
        apply_stimulus("DIV -7/2", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFD, FULL_LAT, 1'b0);
        apply_stimulus("REM -7/2", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd12, 32'hFFFF_FFFF, FULL_LAT, 1'b0);
        apply_stimulus("DIV 7/-2", 3'b100, 32'd7, 32'hFFFF_FFFE, 5'd13, 32'hFFFF_FFFD, FULL_LAT, 1'b0);
        apply_stimulus("REM 7/-2", 3'b110, 32'd7, 32'hFFFF_FFFE, 5'd14, 32'd1, FULL_LAT, 1'b0);
        apply_stimulus("DIVU 100/7", 3'b101, 32'd100, 32'd7, 5'd15, 32'd14, FULL_LAT, 1'b0);
        apply_stimulus("REMU 100/7", 3'b111, 32'd100, 32'd7, 5'd16, 32'd2, FULL_LAT, 1'b0);

        // Overflow and divide-by-zero corners
        apply_stimulus("DIV ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h8000_0000, SPECIAL_LAT, 1'b0);
        apply_stimulus("REM ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'd0, SPECIAL_LAT, 1'b0);
        apply_stimulus("DIVU 5/0", 3'b101, 32'd5, 32'd0, 5'd19, 32'hFFFF_FFFF, SPECIAL_LAT, 1'b0);
        apply_stimulus("REM 5/0", 3'b110, 32'd5, 32'd0, 5'd20, 32'd5, SPECIAL_LAT, 1'b0);
        apply_stimulus("DIV -5/0", 3'b100, 32'hFFFF_FFFB, 32'd0, 5'd21, 32'hFFFF_FFFF, SPECIAL_LAT, 1'b0);

        // Start held high with inputs changing mid-operation, then a back-to-back op to rd=0.
        apply_stimulus("hold DIVU", 3'b101, 32'd100, 32'd7, 5'd22, 32'd14, FULL_LAT, 1'b1);
        apply_stimulus("next MUL rd0", 3'b000, 32'd6, 32'd7, 5'd0, 32'd42, FULL_LAT, 1'b0);

        // Reset pulsed in cycle 10 of a DIVU aborts it silently.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.funct3 = 3'b101;
        bus.op1    = 32'd1000;
        bus.op2    = 32'd3;
        bus.rd_in  = 5'd4;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check_output("abort pre busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_output("abort busy", 32'(bus.busy), 32'd0);
        check_output("abort result", bus.result, 32'd0);
        check_output("abort rd_out", 32'(bus.rd_out), 32'd0);
        activity = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.we || bus.busy) activity = 1'b1;
        end
        check_output("abort quiet", 32'(activity), 32'd0);
        apply_stimulus("MUL 3x4", 3'b000, 32'd3, 32'd4, 5'd1, 32'd12, FULL_LAT, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
